// File: rtl/wb_burst_master_pkg.sv
// wb_burst_master_pkg: shared state encoding for the Wishbone burst master
package wb_burst_master_pkg;
  typedef enum logic {
    IDLE = 1'b0,
    BUS  = 1'b1
  } state_t;
endpackage

// File: rtl/wb_burst_master.sv
// wb_burst_master: pipelined Wishbone master running one burst read or fill write per command
module wb_burst_master
  import wb_burst_master_pkg::*;
#(
  parameter int AW    = 30,
  parameter int DW    = 32,
  parameter int LGLEN = 8
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_cmd_stb,
  input  logic             i_cmd_we,
  input  logic [AW-1:0]    i_cmd_addr,
  input  logic [LGLEN-1:0] i_cmd_len,
  input  logic [DW-1:0]    i_cmd_data,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err,
  output logic             o_rd_stb,
  output logic [DW-1:0]    o_rd_data,
  output logic             o_wb_cyc,
  output logic             o_wb_stb,
  output logic             o_wb_we,
  output logic [AW-1:0]    o_wb_addr,
  output logic [DW-1:0]    o_wb_data,
  output logic [DW/8-1:0]  o_wb_sel,
  input  logic             i_wb_ack,
  input  logic             i_wb_stall,
  input  logic             i_wb_err,
  input  logic [DW-1:0]    i_wb_data
);
  state_t           r_state;
  logic [LGLEN-1:0] r_nreq_left;
  logic [LGLEN-1:0] r_nack_left;
  assign o_wb_sel = '1;
  // Command acceptance, request issue, ack accounting and completion
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= IDLE;
      r_nreq_left <= '0;
      r_nack_left <= '0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_err       <= 1'b0;
      o_rd_stb    <= 1'b0;
      o_rd_data   <= '0;
      o_wb_cyc    <= 1'b0;
      o_wb_stb    <= 1'b0;
      o_wb_we     <= 1'b0;
      o_wb_addr   <= '0;
      o_wb_data   <= '0;
    end else begin
      o_done   <= 1'b0;
      o_err    <= 1'b0;
      o_rd_stb <= 1'b0;
      if (r_state == IDLE) begin
        if (i_cmd_stb && i_cmd_len != '0) begin
          r_state     <= BUS;
          o_busy      <= 1'b1;
          o_wb_cyc    <= 1'b1;
          o_wb_stb    <= 1'b1;
          o_wb_we     <= i_cmd_we;
          o_wb_addr   <= i_cmd_addr;
          o_wb_data   <= i_cmd_data;
          r_nreq_left <= i_cmd_len;
          r_nack_left <= i_cmd_len;
        end else if (i_cmd_stb) begin
          o_done <= 1'b1;
        end
      end else if (i_wb_err) begin
        r_state  <= IDLE;
        o_busy   <= 1'b0;
        o_wb_cyc <= 1'b0;
        o_wb_stb <= 1'b0;
        o_done   <= 1'b1;
        o_err    <= 1'b1;
      end else begin
        if (o_wb_stb && !i_wb_stall) begin
          o_wb_addr   <= o_wb_addr + 1'b1;
          r_nreq_left <= r_nreq_left - 1'b1;
          if (r_nreq_left == 1) o_wb_stb <= 1'b0;
        end
        if (i_wb_ack) begin
          r_nack_left <= r_nack_left - 1'b1;
          o_rd_stb    <= !o_wb_we;
          if (!o_wb_we) o_rd_data <= i_wb_data;
          if (r_nack_left == 1) begin
            r_state  <= IDLE;
            o_busy   <= 1'b0;
            o_wb_cyc <= 1'b0;
            o_wb_stb <= 1'b0;
            o_done   <= 1'b1;
          end
        end
      end
    end
  end
`ifdef FORMAL
  logic [LGLEN:0] f_nreqs;
  logic [LGLEN:0] f_nacks;
  logic [LGLEN:0] f_outstanding;
  formal_master #(
    .AW(AW), .DW(DW), .F_LGDEPTH(LGLEN + 1),
    .F_OPT_RMW_BUS_OPTION(0), .F_OPT_DISCONTINUOUS(0)
  ) u_fwb (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_wb_cyc(o_wb_cyc), .i_wb_stb(o_wb_stb), .i_wb_we(o_wb_we),
    .i_wb_addr(o_wb_addr), .i_wb_data(o_wb_data), .i_wb_sel(o_wb_sel),
    .i_wb_ack(i_wb_ack), .i_wb_stall(i_wb_stall), .i_wb_idata(i_wb_data),
    .i_wb_err(i_wb_err),
    .f_nreqs(f_nreqs), .f_nacks(f_nacks), .f_outstanding(f_outstanding)
  );
  // Counter invariants that let induction close
  always_comb begin
    if (!i_reset && o_wb_cyc) begin
      assert (r_nreq_left <= r_nack_left);
      assert (f_outstanding == {1'b0, r_nack_left - r_nreq_left});
    end
  end
`endif
endmodule

// File: tb/tb_wb_burst_master.sv
// tb_wb_burst_master: directed self-checking bench for wb_burst_master
module tb_wb_burst_master;
  logic        i_clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_cmd_stb = 1'b0;
  logic        i_cmd_we = 1'b0;
  logic [29:0] i_cmd_addr = '0;
  logic [7:0]  i_cmd_len = '0;
  logic [31:0] i_cmd_data = '0;
  logic        o_busy, o_done, o_err, o_rd_stb;
  logic [31:0] o_rd_data;
  logic        o_wb_cyc, o_wb_stb, o_wb_we;
  logic [29:0] o_wb_addr;
  logic [31:0] o_wb_data;
  logic [3:0]  o_wb_sel;
  logic        i_wb_ack = 1'b0;
  logic        i_wb_stall = 1'b0;
  logic        i_wb_err = 1'b0;
  logic [31:0] i_wb_data = '0;
  int tests = 0;
  int fails = 0;

  wb_burst_master dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_cmd_stb(i_cmd_stb), .i_cmd_we(i_cmd_we), .i_cmd_addr(i_cmd_addr),
    .i_cmd_len(i_cmd_len), .i_cmd_data(i_cmd_data),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err),
    .o_rd_stb(o_rd_stb), .o_rd_data(o_rd_data),
    .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we),
    .o_wb_addr(o_wb_addr), .o_wb_data(o_wb_data), .o_wb_sel(o_wb_sel),
    .i_wb_ack(i_wb_ack), .i_wb_stall(i_wb_stall), .i_wb_err(i_wb_err),
    .i_wb_data(i_wb_data)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cmd(input logic we, input logic [29:0] addr, input logic [7:0] len, input logic [31:0] data);
    i_cmd_stb  = 1'b1;
    i_cmd_we   = we;
    i_cmd_addr = addr;
    i_cmd_len  = len;
    i_cmd_data = data;
    tick();
    i_cmd_stb = 1'b0;
  endtask

  initial begin
    tick();
    tick();
    chk("rst_cyc", o_wb_cyc, 0);
    chk("rst_stb", o_wb_stb, 0);
    chk("rst_we", o_wb_we, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_flags", {o_done, o_err, o_rd_stb}, 0);
    chk("rst_addr", o_wb_addr, 0);
    i_reset = 1'b0;
    tick();

    // Read LEN=4 at 0x100, ack one cycle after each strobe
    cmd(1'b0, 30'h100, 8'd4, 32'h0);
    for (int k = 0; k <= 6; k++) begin
      chk($sformatf("r4_stb%0d", k), o_wb_stb, k <= 3);
      chk($sformatf("r4_cyc%0d", k), o_wb_cyc, k <= 4);
      chk($sformatf("r4_busy%0d", k), o_busy, k <= 4);
      chk($sformatf("r4_done%0d", k), o_done, k == 5);
      chk($sformatf("r4_rdstb%0d", k), o_rd_stb, k >= 2 && k <= 5);
      if (k <= 4) chk($sformatf("r4_addr%0d", k), o_wb_addr, 30'h100 + k);
      if (k >= 2 && k <= 5) chk($sformatf("r4_rdata%0d", k), o_rd_data, 32'hA0 + k - 2);
      i_wb_ack  = (k >= 1 && k <= 4);
      i_wb_data = 32'hA0 + k - 1;
      tick();
    end
    i_wb_ack = 1'b0;

    // Fill LEN=3 with 0xDEADBEEF, stall for the first two cycles
    cmd(1'b1, 30'h200, 8'd3, 32'hDEADBEEF);
    for (int k = 0; k <= 7; k++) begin
      chk($sformatf("f3_stb%0d", k), o_wb_stb, k <= 4);
      chk($sformatf("f3_cyc%0d", k), o_wb_cyc, k <= 5);
      chk($sformatf("f3_done%0d", k), o_done, k == 6);
      chk($sformatf("f3_rdstb%0d", k), o_rd_stb, 0);
      if (k <= 5) begin
        chk($sformatf("f3_addr%0d", k), o_wb_addr, k <= 2 ? 30'h200 : 30'h200 + k - 2);
        chk($sformatf("f3_we%0d", k), o_wb_we, 1);
        chk($sformatf("f3_data%0d", k), o_wb_data, 32'hDEADBEEF);
        chk($sformatf("f3_sel%0d", k), o_wb_sel, 4'hF);
      end
      i_wb_stall = (k <= 1);
      i_wb_ack   = (k >= 3 && k <= 5);
      i_wb_data  = 32'h5555_0000 + k;
      tick();
    end
    i_wb_ack = 1'b0;
    i_wb_stall = 1'b0;

    // Read LEN=8, each ack arrives five cycles after its strobe
    cmd(1'b0, 30'h300, 8'd8, 32'h0);
    for (int k = 0; k <= 14; k++) begin
      chk($sformatf("r8_stb%0d", k), o_wb_stb, k <= 7);
      chk($sformatf("r8_cyc%0d", k), o_wb_cyc, k <= 12);
      chk($sformatf("r8_done%0d", k), o_done, k == 13);
      chk($sformatf("r8_rdstb%0d", k), o_rd_stb, k >= 6 && k <= 13);
      if (k <= 8) chk($sformatf("r8_addr%0d", k), o_wb_addr, 30'h300 + k);
      if (k >= 6 && k <= 13) chk($sformatf("r8_rdata%0d", k), o_rd_data, 32'h30 + k - 6);
      i_wb_ack  = (k >= 5 && k <= 12);
      i_wb_data = 32'h30 + k - 5;
      tick();
    end
    i_wb_ack = 1'b0;

    // Read LEN=5, the second response is a bus error
    cmd(1'b0, 30'h400, 8'd5, 32'h0);
    chk("er_stb0", o_wb_stb, 1);
    i_wb_ack = 1'b0;
    tick();
    chk("er_addr1", o_wb_addr, 30'h401);
    i_wb_ack  = 1'b1;
    i_wb_data = 32'h77;
    tick();
    chk("er_rdstb2", o_rd_stb, 1);
    chk("er_rdata2", o_rd_data, 32'h77);
    chk("er_cyc2", o_wb_cyc, 1);
    i_wb_ack = 1'b0;
    i_wb_err = 1'b1;
    tick();
    i_wb_err = 1'b0;
    chk("er_cyc3", o_wb_cyc, 0);
    chk("er_stb3", o_wb_stb, 0);
    chk("er_done3", o_done, 1);
    chk("er_err3", o_err, 1);
    chk("er_busy3", o_busy, 0);
    chk("er_rdstb3", o_rd_stb, 0);
    i_wb_ack = 1'b1;
    tick();
    tick();
    i_wb_ack = 1'b0;
    chk("er_late_done", o_done, 0);
    chk("er_late_rdstb", o_rd_stb, 0);
    chk("er_late_cyc", o_wb_cyc, 0);
    cmd(1'b0, 30'h500, 8'd1, 32'h0);
    chk("er_new_addr", o_wb_addr, 30'h500);
    chk("er_new_stb", o_wb_stb, 1);
    i_wb_ack  = 1'b1;
    i_wb_data = 32'hCAFE;
    tick();
    i_wb_ack = 1'b0;
    chk("er_new_done", o_done, 1);
    chk("er_new_err", o_err, 0);
    chk("er_new_rdata", o_rd_data, 32'hCAFE);
    tick();

    // LEN=0 produces only a done pulse
    cmd(1'b0, 30'h123, 8'd0, 32'h0);
    chk("z_cyc0", o_wb_cyc, 0);
    chk("z_done0", o_done, 1);
    chk("z_busy0", o_busy, 0);
    tick();
    chk("z_cyc1", o_wb_cyc, 0);
    chk("z_done1", o_done, 0);

    // Reset after three accepted requests of a LEN=6 write, then a clean read
    cmd(1'b1, 30'h600, 8'd6, 32'h11);
    tick();
    tick();
    tick();
    chk("rs_addr3", o_wb_addr, 30'h603);
    chk("rs_cyc3", o_wb_cyc, 1);
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    chk("rs_cyc", o_wb_cyc, 0);
    chk("rs_stb", o_wb_stb, 0);
    chk("rs_done", o_done, 0);
    tick();
    chk("rs_done2", o_done, 0);
    cmd(1'b0, 30'h700, 8'd2, 32'h0);
    for (int k = 0; k <= 3; k++) begin
      chk($sformatf("rs_stb%0d", k), o_wb_stb, k <= 1);
      chk($sformatf("rs_cycn%0d", k), o_wb_cyc, k <= 2);
      chk($sformatf("rs_donen%0d", k), o_done, k == 3);
      if (k <= 1) chk($sformatf("rs_addrn%0d", k), o_wb_addr, 30'h700 + k);
      if (k >= 2) chk($sformatf("rs_rdata%0d", k), o_rd_data, 32'hB0 + k - 2);
      i_wb_ack  = (k >= 1 && k <= 2);
      i_wb_data = 32'hB0 + k - 1;
      tick();
    end
    i_wb_ack = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/wb_burst_master.md
Name: wb_burst_master

Overview:
Pipelined Wishbone (B4 pipelined) bus master. It executes one command at a time, either a burst read or a constant-fill burst write of LEN consecutive words.
It sits between a command source (debug bridge / DMA controller) and the Wishbone interconnect. Its bus side is the master that the team's formal_master property checker constrains.
It issues strobes back-to-back, tracks outstanding acks, streams read data out and reports done or error.

Parameters:
AW, 30, word-address width
DW, 32, data width
LGLEN, 8, burst length counter width; LEN range 1..2^LGLEN-1

Ports:
i_clk  in  1  clock
i_reset  in  1  synchronous active-high reset
i_cmd_stb  in  1  command valid; accepted only when !o_busy
i_cmd_we  in  1  1 = fill write, 0 = burst read
i_cmd_addr  in  AW  first word address
i_cmd_len  in  LGLEN  number of words
i_cmd_data  in  DW  fill value (writes)
o_busy  out  1  command in progress
o_done  out  1  one-cycle completion pulse
o_err  out  1  one-cycle pulse with o_done on bus error
o_rd_stb  out  1  read word valid (no backpressure)
o_rd_data  out  DW  read word
o_wb_cyc, o_wb_stb, o_wb_we  out  1 each  bus controls
o_wb_addr  out  AW  bus address
o_wb_data  out  DW  bus write data
o_wb_sel  out  DW/8  byte selects, always all ones
i_wb_ack, i_wb_stall, i_wb_err  in  1 each  slave responses
i_wb_data  in  DW  slave read data

Behaviour:
- Reset: o_wb_cyc=o_wb_stb=o_wb_we=0, o_busy=o_done=o_err=o_rd_stb=0; addr/data/counters 0. Reset mid-burst drops cyc and stb on the next edge and emits no o_done.
- States: IDLE, BUS. All outputs are registered.
- IDLE: when i_cmd_stb is high:
  - LEN!=0: next cycle cyc=stb=1, busy=1. Latch we, addr, data; nreq_left=LEN, nack_left=LEN. State goes to BUS.
  - LEN==0: no bus activity; o_done=1 on the next cycle.
- BUS, request side: while stb && !i_wb_stall, the request is accepted. Then addr+1 and nreq_left-1. If that was the last request, stb=0 on the next cycle.
- BUS, stall: while stb && i_wb_stall, stb, we, addr, data and sel are held unchanged.
- BUS, no re-raise: once stb falls, it never rises again within the same cyc.
- BUS, ack side: each i_wb_ack decrements nack_left.
  - On reads, the ack also gives o_rd_stb=1 and o_rd_data=i_wb_data on the next cycle.
  - Ack and accepted strobe in the same cycle: both counters update.
- Completion: an ack with nack_left==1 gives cyc=0, busy=0, o_done=1 on the next cycle. Return to IDLE.
- Error: i_wb_err at any cycle in BUS gives cyc=stb=0, o_done=o_err=1 on the next cycle. Remaining requests and acks are abandoned. Return to IDLE.
- cyc never rises without stb. cyc is never high with nothing outstanding and stb low.
- Outstanding count never exceeds LEN, which is ≤ 2^LGLEN-1.
- Address wraps modulo 2^AW silently.
- A new command is accepted no earlier than the cycle after o_done, i.e. when o_busy=0.
- Commands presented while busy are ignored; this is not an error.
- Under `ifdef FORMAL`, instantiate formal_master with:
  - F_LGDEPTH=LGLEN+1, F_OPT_RMW_BUS_OPTION=0, F_OPT_DISCONTINUOUS=0.
  - Prove with k-induction.
  - Assert nreq_left ≤ nack_left and f_outstanding == nack_left-nreq_left while cyc.

Decomposition:
- State encoding localparams (IDLE=1'b0, BUS=1'b1) and the all-ones sel constant go in the shared Wishbone include file.
- No sub-module; the outstanding/remaining counters stay inline.
- Formal checker instance only under FORMAL.

Test Plan:
- Read LEN=4 at 0x100, no stall, ack 1 cycle after each stb:
  - addrs 0x100..0x103 on 4 consecutive cycles;
  - 4 o_rd_stb pulses;
  - cyc drops the cycle after the 4th ack;
  - o_done one cycle.
- Fill LEN=3, data 0xDEADBEEF, i_wb_stall high for the first 2 cycles:
  - addr/data held during stall;
  - o_wb_we=1, sel=4'hF;
  - 3 accepted writes, then done.
- Read LEN=8 with ack delayed 5 cycles and overlapping new strobes:
  - no stb re-raise;
  - 8 read words in order;
  - o_done after the 8th ack.
- Error on the 2nd ack of LEN=5:
  - cyc=stb=0 next cycle;
  - o_done=o_err=1 same cycle;
  - later acks ignored;
  - a new command is accepted after that.
- LEN=0 command: no cyc ever; o_done one cycle later.
- i_reset asserted mid-burst (LEN=6, after 3 requests):
  - cyc/stb low next cycle, no o_done;
  - the next command runs cleanly.
